// File: rtl/pwm_shadow_gen.sv
// PWM generator with a one-deep shadow register for duty/period/mode updates.
// Updates take effect only at a period boundary, so output periods are never truncated.
module pwm_shadow_gen #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] duty_cycle,
   input  logic [WIDTH-1:0] period,
   input  logic             center_mode,
   input  logic             upd_valid,
   output logic             upd_ready,
   output logic             pwm_out,
   output logic             cycle_start
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] act_period_q, act_period_d;
   logic [WIDTH-1:0] act_duty_q, act_duty_d;
   logic             act_center_q, act_center_d;
   logic [WIDTH-1:0] pend_period_q, pend_period_d;
   logic [WIDTH-1:0] pend_duty_q, pend_duty_d;
   logic             pend_center_q, pend_center_d;
   logic             pend_full_q, pend_full_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             down_q, down_d;
   logic             pwm_q, pwm_d;
   logic             cs_q, cs_d;

   logic accept;
   logic per_zero;
   logic at_top;
   logic bnd;
   logic term;

   always_comb begin
      accept   = upd_valid && !pend_full_q;
      per_zero = (act_period_q == '0);
      at_top   = (cnt_q == act_period_q - ONE);
      bnd      = per_zero
               || (!act_center_q && at_top)
               || (act_center_q && down_q && (cnt_q == '0))
               || (act_center_q && (act_period_q == ONE));

      // The subtraction in the center compare only runs when duty < period, so it never wraps.
      if (per_zero || (act_duty_q == '0))
         term = 1'b0;
      else if (act_duty_q >= act_period_q)
         term = 1'b1;
      else if (act_center_q)
         term = (cnt_q >= act_period_q - act_duty_q);
      else
         term = (cnt_q < act_duty_q);

      act_period_d  = act_period_q;
      act_duty_d    = act_duty_q;
      act_center_d  = act_center_q;
      pend_period_d = pend_period_q;
      pend_duty_d   = pend_duty_q;
      pend_center_d = pend_center_q;
      pend_full_d   = pend_full_q;
      cnt_d         = cnt_q;
      down_d        = down_q;

      if (bnd && pend_full_q) begin
         act_period_d = pend_period_q;
         act_duty_d   = pend_duty_q;
         act_center_d = pend_center_q;
         pend_full_d  = 1'b0;
         cnt_d        = '0;
         down_d       = 1'b0;
      end else if (per_zero) begin
         cnt_d  = '0;
         down_d = 1'b0;
      end else if (!act_center_q) begin
         cnt_d  = at_top ? '0 : cnt_q + ONE;
         down_d = 1'b0;
      end else if (!down_q) begin
         // Turnaround ticks hold cnt so each extreme is visited twice.
         if (at_top) down_d = 1'b1;
         else        cnt_d  = cnt_q + ONE;
      end else begin
         if (cnt_q == '0) down_d = 1'b0;
         else             cnt_d  = cnt_q - ONE;
      end

      // A load needs pend_full set and an accept needs it clear, so they never collide.
      if (accept) begin
         pend_period_d = period;
         pend_duty_d   = duty_cycle;
         pend_center_d = center_mode;
         pend_full_d   = 1'b1;
      end

      pwm_d = term;
      cs_d  = !per_zero && (cnt_q == '0) && !down_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_period_q  <= '0;
         act_duty_q    <= '0;
         act_center_q  <= 1'b0;
         pend_period_q <= '0;
         pend_duty_q   <= '0;
         pend_center_q <= 1'b0;
         pend_full_q   <= 1'b0;
         cnt_q         <= '0;
         down_q        <= 1'b0;
         pwm_q         <= 1'b0;
         cs_q          <= 1'b0;
      end else begin
         act_period_q  <= act_period_d;
         act_duty_q    <= act_duty_d;
         act_center_q  <= act_center_d;
         pend_period_q <= pend_period_d;
         pend_duty_q   <= pend_duty_d;
         pend_center_q <= pend_center_d;
         pend_full_q   <= pend_full_d;
         cnt_q         <= cnt_d;
         down_q        <= down_d;
         pwm_q         <= pwm_d;
         cs_q          <= cs_d;
      end
   end

   assign upd_ready   = !pend_full_q;
   assign pwm_out     = pwm_q;
   assign cycle_start = cs_q;

endmodule
